arb_req_frontend: RTL
=====================

# arb_req_frontend

Per-requester ingress buffering that sits directly upstream of the 4-port round-robin arbiter. Each of four clients pushes words into its own FIFO. A non-empty FIFO raises that port's REQ. While the arbiter holds GNT on a port, the block drains one word per cycle from that FIFO into a single registered output stream tagged with the source port.

## Interface
**Parameters**
- DATA_W, default 8: payload width per word.
- DEPTH, default 4: entries per port FIFO; must be a power of two and ≥ 2.

**Ports**
- clk, input, 1: single clock; all state updates on its rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- in_valid, input, 4: bit i set means client i offers a word.
- in_data, input, 4*DATA_W: client i data at bits [i*DATA_W +: DATA_W].
- in_ready, output, 4: bit i set means FIFO i can accept a word.
- REQ, output, 4: to arbiter; bit i set means FIFO i is non-empty.
- GNT, input, 4: from arbiter; one-hot or zero.
- out_valid, output, 1: output word present.
- out_data, output, DATA_W: output payload.
- out_port, output, 2: index of the source FIFO of out_data.
- out_ready, input, 1: downstream accepts the word when out_valid && out_ready.
- gnt_err, output, 1: one-cycle pulse flagging a multi-hot GNT.

## Operation
- **FIFO state.** Four independent circular FIFOs. Each has a write pointer, a read pointer and a count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- **in_ready.** in_ready[i] = (count_i < DEPTH), decoded from registered count. There is no same-cycle bypass: a full FIFO that pops this cycle still refuses a push this cycle.
- **Push.** push_i = in_valid[i] && in_ready[i]. Writes in_data slice i at wptr_i, then increments wptr_i.
- **REQ.** REQ[i] = (count_i != 0), decoded from registered state only, with no combinational path from inputs.
- **Output slot free.** out_free = !out_valid || out_ready.
- **Pop.** pop_i = GNT[i] && REQ[i] && out_free && onehot(GNT).
  - Reads the entry at rptr_i and increments rptr_i.
  - On the same edge: out_data ← that entry, out_port ← i, out_valid ← 1.
- **Output drain.** If out_valid && out_ready and there is no pop, out_valid ← 0. out_data and out_port hold their last values.
- **Count update.** count_i += push_i − pop_i. A simultaneous push and pop leaves the count unchanged.
- **GNT = 0.** No pop.
- **GNT to an empty port.** Allowed, because the arbiter's time slice may outlast the data. No pop, no error.
- **Multi-hot GNT.** No pop from any port. gnt_err ← 1 for exactly one cycle per offending cycle.
- **Backpressure.** When out_valid && !out_ready, no pop occurs and the output registers hold. The grant is simply wasted; REQ stays high.
- **Reset** (asynchronous, any time, including mid-transfer), state after assertion:
  - All pointers and counts are 0 and FIFO contents are discarded.
  - REQ = 4'b0000 and in_ready = 4'b1111.
  - out_valid = 0, out_data = 0, out_port = 0, gnt_err = 0.
  - Storage RAM need not be reset.

## Timing
- **Push to REQ:** push accepted at edge k gives REQ[i] = 1 after edge k. The arbiter sees it for the cycle following k.
- **GNT to output:** GNT sampled at edge k with a pop gives out_valid = 1 with that word after edge k (1-cycle latency).
- **Sustained rate:** one word per cycle while GNT is held, the FIFO is non-empty and out_ready = 1.
- **Last-word pop:** popping the final word at edge k gives REQ[i] = 0 after edge k.
- **Full FIFO:** in_ready[i] = 0 in the cycle after count reaches DEPTH. It returns to 1 in the cycle after the first pop.
- **Ordering:** FIFO order within a port is strict. Cross-port order follows the GNT sequence.

## Test plan
1. **Reset values.** Drive rst_n low mid-cycle with FIFO 2 holding 3 words.
   - Immediately: REQ = 0, in_ready = 4'hF, out_valid = 0.
   - After release: no stale data emerges.
2. **Single port, fill and drain.** Push 0x11, 0x22, 0x33, 0x44 into port 3 (DEPTH = 4).
   - in_ready[3] = 0 and REQ = 4'b1000.
   - Hold GNT = 4'b1000 with out_ready = 1: out_data is 0x11, 0x22, 0x33, 0x44 on consecutive cycles with out_port = 3.
   - REQ[3] = 0 after the 4th pop.
3. **Push and pop together.** Port 1 holds 2 words. Push and pop it in the same cycle.
   - count stays 2.
   - Output order preserves FIFO order across the pointer wrap-around.
4. **Backpressure.** GNT = 4'b0010, out_ready = 0 for 3 cycles.
   - out_valid stays 1 and out_data is stable.
   - No extra pops; count_1 decreases by exactly 1.
5. **Grant rotation.** Ports 1, 2 and 3 are non-empty. Drive GNT through 0010, 0100, 1000.
   - out_port follows 1, 2, 3 with 1-cycle latency.
   - GNT = 0001 with port 0 empty gives no out_valid and gnt_err = 0.
6. **Multi-hot GNT.** GNT = 4'b0110 for one cycle.
   - gnt_err pulses 1 for one cycle.
   - No FIFO count changes and out_valid does not assert from that cycle.

Source files
------------

// File: rtl/arb_req_frontend.sv
// rtl/arb_req_frontend.sv - four per-client FIFOs drained by a one-hot grant into one registered tagged stream
// REQ and in_ready decode registered counts only, so the arbiter sees no combinational path from in_valid.
module arb_req_frontend #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          in_valid,
  input  logic [4*DATA_W-1:0] in_data,
  output logic [3:0]          in_ready,
  output logic [3:0]          REQ,
  input  logic [3:0]          GNT,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          out_port,
  input  logic                out_ready,
  output logic                gnt_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [4][DEPTH];
  logic [AW-1:0]     wptr_q [4];
  logic [AW-1:0]     wptr_d [4];
  logic [AW-1:0]     rptr_q [4];
  logic [AW-1:0]     rptr_d [4];
  logic [CW-1:0]     cnt_q  [4];
  logic [CW-1:0]     cnt_d  [4];

  logic [3:0]        push;
  logic [3:0]        pop;
  logic              gnt_multi;
  logic              gnt_onehot;
  logic              out_free;
  logic              pop_any;
  logic [1:0]        pop_idx;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_port_q, out_port_d;
  logic              gnt_err_q, gnt_err_d;

  always_comb begin
    gnt_multi  = (GNT & (GNT - 4'd1)) != 4'd0;
    gnt_onehot = (GNT != 4'd0) && !gnt_multi;
    out_free   = !out_valid_q || out_ready;
    pop_any    = 1'b0;
    pop_idx    = 2'd0;
    in_ready   = 4'b0000;
    REQ        = 4'b0000;
    push       = 4'b0000;
    pop        = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      in_ready[i] = cnt_q[i] < CW'(DEPTH);
      REQ[i]      = cnt_q[i] != '0;
      push[i]     = in_valid[i] && in_ready[i];
      pop[i]      = GNT[i] && REQ[i] && out_free && gnt_onehot;
      wptr_d[i]   = wptr_q[i] + AW'(push[i]);
      rptr_d[i]   = rptr_q[i] + AW'(pop[i]);
      cnt_d[i]    = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      if (pop[i]) begin
        pop_any = 1'b1;
        pop_idx = 2'(i);
      end
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_port_d  = out_port_q;
    if (pop_any) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[pop_idx][rptr_q[pop_idx]];
      out_port_d  = pop_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    gnt_err_d = gnt_multi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_port_q  <= 2'd0;
      gnt_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_port_q  <= out_port_d;
      gnt_err_q   <= gnt_err_d;
    end
  end

  // Storage is left unreset; the counts alone decide what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) mem_q[i][wptr_q[i]] <= in_data[i*DATA_W +: DATA_W];
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_port  = out_port_q;
  assign gnt_err   = gnt_err_q;

endmodule
